// File: rtl/fp_pkg.sv
// Shared definitions for the parametrised floating-point multiplier.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Format helpers for {sgn, exp, man} words of arbitrary EXP_W/MAN_W:
//   fp_bias  - exponent bias for a given exponent width
//   fp_max   - saturated magnitude pattern (all-ones exp and man) with a sign bit
//   fp_zero  - flushed-to-zero pattern
//   FLAG_*   - bit positions inside the packed status-flag vector
package fp_pkg;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_W    = 3;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Returned 64 bits wide; callers size-cast to their word width.
    function automatic logic [63:0] fp_max(input logic sgn, input int exp_w, input int man_w);
        logic [63:0] r;
        r = (64'd1 << (exp_w + man_w)) - 64'd1;
        r[exp_w + man_w] = sgn;
        return r;
    endfunction

    function automatic logic [63:0] fp_zero();
        return 64'd0;
    endfunction

endpackage

// File: rtl/fp_mant_mult.sv
// Unsigned NxN mantissa multiplier, operand register then product register.
// Latency: 2 cycles while en_i is high.
// Backpressure: both register stages hold their contents while en_i is low.
// Ports: clk_i/rst_i clock and async active-high reset, en_i advance enable,
//        a_i/b_i operands, p_o registered 2N-bit product.
module fp_mant_mult #(
    parameter int N = 7
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);

    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [2*N-1:0] r_p;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a <= '0;
            r_b <= '0;
            r_p <= '0;
        end else if (en_i) begin
            r_a <= a_i;
            r_b <= b_i;
            r_p <= {{N{1'b0}}, r_a} * {{N{1'b0}}, r_b};
        end
    end

    assign p_o = r_p;

endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined {sgn, exp, man} multiplier with round-to-nearest-even, saturation and flush.
// Latency: 3 cycles accept-to-valid_o, throughput 1/cycle.
// Backpressure: whole pipe freezes while valid_o & ~ready_i; ready_o = ~stall, no bubble collapse.
// Ports: clk_i, rst_i (async, active-high); valid_i/ready_o/data_1_i/data_2_i operand side;
//        valid_o/ready_i/data_mult_o product side; zero_o/ovf_o/unf_o flags qualified by valid_o.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W    = 5,
    parameter int MAN_W    = 6,
    parameter int ROUND_EN = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [EXP_W+MAN_W:0]   data_1_i,
    input  logic [EXP_W+MAN_W:0]   data_2_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [EXP_W+MAN_W:0]   data_mult_o,
    output logic                   zero_o,
    output logic                   ovf_o,
    output logic                   unf_o
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW2  = EXP_W + 2;
    localparam int MW1  = MAN_W + 1;
    localparam int PW   = 2 * MW1;
    localparam int BIAS = fp_bias(EXP_W);
    localparam logic signed [EW2-1:0] P_EMAX = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] P_E0   = '0;
    localparam logic [W-1:0]          P_ZERO = W'(fp_zero());

    logic                  w_stall;
    logic                  w_en;
    logic [EXP_W-1:0]      w_ea, w_eb;
    logic [MAN_W-1:0]      w_ma, w_mb;
    logic signed [EW2-1:0] w_esum;
    logic [PW-1:0]         w_prod;

    // S1: sign, biased exponent sum, zero detect
    logic                  r_vld1, r_sgn1, r_zero1;
    logic signed [EW2-1:0] r_esum1;
    // S2: exponent range decided ahead of time for every possible increment
    logic                  r_vld2, r_sgn2, r_zero2;
    logic signed [EW2-1:0] r_esum2;
    logic [3:0]            w_unf_pre, w_ovf_pre, r_unf2, r_ovf2;
    // S3: output register
    logic                  r_vld3;
    logic [W-1:0]          r_dat3;
    logic [FLAG_W-1:0]     r_flags3;

    assign w_stall = r_vld3 & ~ready_i;
    assign w_en    = ~w_stall;
    assign ready_o = w_en;

    assign w_ea   = data_1_i[W-2 -: EXP_W];
    assign w_eb   = data_2_i[W-2 -: EXP_W];
    assign w_ma   = data_1_i[MAN_W-1:0];
    assign w_mb   = data_2_i[MAN_W-1:0];
    assign w_esum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - $signed(EW2'(BIAS));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld1  <= 1'b0;
            r_sgn1  <= 1'b0;
            r_zero1 <= 1'b0;
            r_esum1 <= '0;
        end else if (w_en) begin
            r_vld1  <= valid_i;
            r_sgn1  <= data_1_i[W-1] ^ data_2_i[W-1];
            r_zero1 <= (w_ea == '0) | (w_eb == '0);
            r_esum1 <= w_esum;
        end
    end

    fp_mant_mult #(.N(MW1)) u_mant_mult (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_en),
        .a_i   ({1'b1, w_ma}),
        .b_i   ({1'b1, w_mb}),
        .p_o   (w_prod)
    );

    // Normalise plus rounding carry adds 0..2 to the exponent; index 3 is never selected.
    always_comb begin
        w_unf_pre = '0;
        w_ovf_pre = '0;
        for (int k = 0; k < 4; k++) begin
            w_unf_pre[k] = (r_esum1 + $signed(EW2'(k))) <= P_E0;
            w_ovf_pre[k] = (r_esum1 + $signed(EW2'(k))) >  P_EMAX;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld2  <= 1'b0;
            r_sgn2  <= 1'b0;
            r_zero2 <= 1'b0;
            r_esum2 <= '0;
            r_unf2  <= '0;
            r_ovf2  <= '0;
        end else if (w_en) begin
            r_vld2  <= r_vld1;
            r_sgn2  <= r_sgn1;
            r_zero2 <= r_zero1;
            r_esum2 <= r_esum1;
            r_unf2  <= w_unf_pre;
            r_ovf2  <= w_ovf_pre;
        end
    end

    // S3: product is in [1,4); the top bit selects a one-place right shift.
    logic               w_norm, w_g, w_s, w_rup;
    logic [MAN_W-1:0]   w_man;
    logic [MAN_W:0]     w_man_r;
    logic [1:0]         w_inc;
    logic [EXP_W-1:0]   w_exp;
    logic [W-1:0]       w_dat3;
    logic [FLAG_W-1:0]  w_flags3;

    assign w_norm  = w_prod[PW-1];
    assign w_man   = w_norm ? w_prod[2*MAN_W -: MAN_W] : w_prod[2*MAN_W-1 -: MAN_W];
    assign w_g     = w_norm ? w_prod[MAN_W] : w_prod[MAN_W-1];
    assign w_s     = w_norm ? |w_prod[MAN_W-1:0] : |w_prod[MAN_W-2:0];
    assign w_rup   = (ROUND_EN != 0) & w_g & (w_s | w_man[0]);
    // A carry out of the mantissa leaves the low bits all zero, which is the required 1.0 pattern.
    assign w_man_r = {1'b0, w_man} + {{MAN_W{1'b0}}, w_rup};
    assign w_inc   = {1'b0, w_norm} + {1'b0, w_man_r[MAN_W]};
    assign w_exp   = EXP_W'(r_esum2 + $signed({{(EW2-2){1'b0}}, w_inc}));

    always_comb begin
        w_dat3   = {r_sgn2, w_exp, w_man_r[MAN_W-1:0]};
        w_flags3 = '0;
        if (r_zero2) begin
            w_dat3              = P_ZERO;
            w_flags3[FLAG_ZERO] = 1'b1;
        end else if (r_unf2[w_inc]) begin
            w_dat3              = P_ZERO;
            w_flags3[FLAG_UNF]  = 1'b1;
        end else if (r_ovf2[w_inc]) begin
            w_dat3              = W'(fp_max(r_sgn2, EXP_W, MAN_W));
            w_flags3[FLAG_OVF]  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld3   <= 1'b0;
            r_dat3   <= '0;
            r_flags3 <= '0;
        end else if (w_en) begin
            r_vld3   <= r_vld2;
            r_dat3   <= w_dat3;
            r_flags3 <= w_flags3;
        end
    end

    assign valid_o     = r_vld3;
    assign data_mult_o = r_dat3;
    assign zero_o      = r_flags3[FLAG_ZERO];
    assign ovf_o       = r_flags3[FLAG_OVF];
    assign unf_o       = r_flags3[FLAG_UNF];

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe at the default 1/5/6 format, rounding and truncating instances in parallel.
// Latency: expects results 3 cycles after accept, plus any stalled cycles.
// Backpressure: drives ready_i low in bursts and expects ordered, stable, lossless output.
module tb_fp_mult_pipe;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i, ready_i;
    logic [W-1:0] d1, d2;

    logic         rdy_a, vld_a, z_a, o_a, u_a;
    logic [W-1:0] dat_a;
    logic         rdy_b, vld_b, z_b, o_b, u_b;
    logic [W-1:0] dat_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp_mult_pipe #(.EXP_W(5), .MAN_W(6), .ROUND_EN(1)) u_rne (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy_a),
        .data_1_i(d1), .data_2_i(d2), .valid_o(vld_a), .ready_i(ready_i),
        .data_mult_o(dat_a), .zero_o(z_a), .ovf_o(o_a), .unf_o(u_a)
    );

    fp_mult_pipe #(.EXP_W(5), .MAN_W(6), .ROUND_EN(0)) u_trn (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy_b),
        .data_1_i(d1), .data_2_i(d2), .valid_o(vld_b), .ready_i(ready_i),
        .data_mult_o(dat_b), .zero_o(z_b), .ovf_o(o_b), .unf_o(u_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result encoded as {unf, ovf, zero, data[11:0]}, from value arithmetic on the operands.
    function automatic logic [14:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit rnd);
        int ea, eb, ma, mb, p, sh, q, rem, half, e;
        logic sg;
        ea = int'(a[10:6]);  eb = int'(b[10:6]);
        ma = int'(a[5:0]);   mb = int'(b[5:0]);
        sg = a[11] ^ b[11];
        if (ea == 0 || eb == 0) return 15'h1000;
        p    = (64 + ma) * (64 + mb);
        sh   = (p >= 8192) ? 7 : 6;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 1 << (sh - 1);
        e    = ea + eb - 15 + (sh - 6);
        if (rnd && (rem > half || (rem == half && (q % 2) == 1))) q++;
        if (q == 128) begin q = 64; e++; end
        if (e <= 0) return 15'h4000;
        if (e > 31) return {3'b010, sg, 11'h7FF};
        return {3'b000, sg, 5'(e), 6'(q - 64)};
    endfunction

    typedef struct {
        logic [14:0] e_rne;
        logic [14:0] e_trn;
        int          left;
    } item_t;
    item_t q[$];
    bit    prev_stall = 1'b0;

    // Inputs only change just after posedge, so each negedge sees the values the next edge will act on.
    always @(negedge clk) begin : mon
        bit exp_v;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
            chk("rst_valid_o", {31'd0, vld_a | vld_b}, 32'd0);
            chk("rst_outputs", {6'd0, dat_a, dat_b, z_a, o_a, u_a, z_b, o_b, u_b}, 32'd0);
        end else begin
            if (!prev_stall)
                foreach (q[i]) if (q[i].left > 0) q[i].left--;
            exp_v = (q.size() > 0) && (q[0].left == 0);
            chk("valid_o", {30'd0, vld_b, vld_a}, {30'd0, exp_v, exp_v});
            chk("ready_o", {30'd0, rdy_b, rdy_a}, {30'd0, {2{~(exp_v & ~ready_i)}}});
            if (exp_v) begin
                chk("rne_result", {17'd0, u_a, o_a, z_a, dat_a}, {17'd0, q[0].e_rne});
                chk("trn_result", {17'd0, u_b, o_b, z_b, dat_b}, {17'd0, q[0].e_trn});
            end
            if (exp_v && ready_i) void'(q.pop_front());
            if (valid_i && rdy_a)
                q.push_back('{e_rne: model(d1, d2, 1'b1), e_trn: model(d1, d2, 1'b0), left: 3});
            prev_stall = exp_v && !ready_i;
        end
    end

    // {a, b, expected rounded, expected truncated}
    localparam int NV = 13;
    logic [W-1:0]  va [NV] = '{12'h3C0, 12'h3E0, 12'hC00, 12'h3C1, 12'h7FF, 12'h040, 12'h000,
                               12'h3E0, 12'h7FF, 12'hFFF, 12'h040, 12'h040, 12'hBC0};
    logic [W-1:0]  vb [NV] = '{12'h3C0, 12'h3E0, 12'h3E0, 12'h3E0, 12'h7FF, 12'h040, 12'hBC0,
                               12'h3D5, 12'h3C0, 12'h400, 12'h380, 12'h3C0, 12'hBC0};
    logic [14:0]   vr [NV] = '{15'h03C0, 15'h0408, 15'h0C20, 15'h03E2, 15'h27FF, 15'h4000, 15'h1000,
                               15'h0400, 15'h07FF, 15'h2FFF, 15'h4000, 15'h0040, 15'h03C0};
    logic [14:0]   vt [NV] = '{15'h03C0, 15'h0408, 15'h0C20, 15'h03E1, 15'h27FF, 15'h4000, 15'h1000,
                               15'h03FF, 15'h07FF, 15'h2FFF, 15'h4000, 15'h0040, 15'h03C0};

    // Called just after a posedge; returns just after the posedge that accepted the operands.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        ok      = 1'b0;
        valid_i = 1'b1;
        d1      = a;
        d2      = b;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = rdy_a;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        chk("send_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_empty();
        for (int t = 0; t < 40 && q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        d1      = '0;
        d2      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_o", {31'd0, vld_a}, 32'd0);
        chk("reset_data", {17'd0, u_a, o_a, z_a, dat_a}, 32'd0);
        chk("reset_ready_o", {30'd0, rdy_b, rdy_a}, 32'd3);
        rst = 1'b0;

        // Pin the model to hand-computed values.
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("model_rne_%0d", i), {17'd0, model(va[i], vb[i], 1'b1)}, {17'd0, vr[i]});
            chk($sformatf("model_trn_%0d", i), {17'd0, model(va[i], vb[i], 1'b0)}, {17'd0, vt[i]});
        end

        // Isolated operations: exact latency and per-vector result.
        @(posedge clk); #1;
        for (int i = 0; i < NV; i++) begin
            send(va[i], vb[i]);
            wait_empty();
        end

        // Back-to-back at full throughput.
        for (int i = 0; i < NV; i++) send(va[i], vb[NV-1-i]);
        wait_empty();

        // Back-pressure: ready_i low for 5 cycles while 6 operands are offered.
        fork
            begin
                ready_i = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
            begin
                for (int i = 0; i < 3; i++) send(va[i+1], vb[i+7]);
                @(negedge clk);
                chk("bp_ready_drop", {31'd0, rdy_a}, 32'd0);
                @(posedge clk); #1;
                for (int i = 3; i < 6; i++) send(va[i+1], vb[i+7]);
            end
        join
        wait_empty();

        // Reset with two results in flight.
        send(va[0], vb[0]);
        send(va[1], vb[1]);
        @(posedge clk); #1;
        chk("pre_reset_valid", {31'd0, vld_a}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_reset_valid", {31'd0, vld_a}, 32'd0);
        chk("mid_reset_data", {17'd0, u_a, o_a, z_a, dat_a}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(va[3], vb[3]);
        wait_empty();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
